// File: rtl/fixed_to_rgb_packer.sv
// Rounds and saturates signed fixed-point colour channels to RGB888, packs them and tags
// each pixel with raster coordinates. Two-stage valid/ready pipeline.
module fixed_to_rgb_packer #(
    parameter int unsigned WIDTH     = 24,
    parameter int unsigned Q_BITS    = 12,
    parameter int unsigned RGB_WIDTH = 8,
    parameter int unsigned H_RES     = 640,
    parameter int unsigned V_RES     = 480
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [WIDTH-1:0]    r_in,
    input  logic signed [WIDTH-1:0]    g_in,
    input  logic signed [WIDTH-1:0]    b_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3*RGB_WIDTH-1:0]     rgb_out,
    output logic [$clog2(H_RES)-1:0]   x_out,
    output logic [$clog2(V_RES)-1:0]   y_out,
    output logic                       eol_out,
    output logic                       eof_out,
    output logic                       sat_out
);

    localparam int unsigned XW = $clog2(H_RES);
    localparam int unsigned YW = $clog2(V_RES);
    localparam int unsigned QW = WIDTH - Q_BITS + 1;
    localparam logic [XW-1:0] XLast = XW'(H_RES - 1);
    localparam logic [YW-1:0] YLast = YW'(V_RES - 1);
    localparam logic [WIDTH:0] Half = (WIDTH + 1)'(1) << (Q_BITS - 1);
    localparam logic [QW-1:0] QMax = QW'((1 << RGB_WIDTH) - 1);

    // Returns {clamped, channel}. The sum is formed one bit wider so it cannot overflow.
    function automatic logic [RGB_WIDTH:0] round_clamp(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] t;
        logic [QW-1:0]  q;
        t = {v[WIDTH-1], v} + Half;
        q = QW'(t >> Q_BITS);
        if (t[WIDTH]) begin
            return {1'b1, {RGB_WIDTH{1'b0}}};
        end else if (q > QMax) begin
            return {1'b1, {RGB_WIDTH{1'b1}}};
        end else begin
            return {1'b0, q[RGB_WIDTH-1:0]};
        end
    endfunction

    logic                   s1_valid_q, s1_valid_d;
    logic [3*RGB_WIDTH-1:0] s1_rgb_q, s1_rgb_d;
    logic                   s1_sat_q, s1_sat_d;
    logic                   out_valid_q, out_valid_d;
    logic [3*RGB_WIDTH-1:0] rgb_q, rgb_d;
    logic                   sat_q, sat_d;
    logic [XW-1:0]          x_q, x_d;
    logic [YW-1:0]          y_q, y_d;

    logic [RGB_WIDTH:0] conv_r, conv_g, conv_b;
    logic               s2_advance, s1_advance;

    always_comb begin
        conv_r = round_clamp(r_in);
        conv_g = round_clamp(g_in);
        conv_b = round_clamp(b_in);

        s2_advance = !out_valid_q || out_ready;
        s1_advance = !s1_valid_q || s2_advance;

        s1_valid_d  = s1_valid_q;
        s1_rgb_d    = s1_rgb_q;
        s1_sat_d    = s1_sat_q;
        out_valid_d = out_valid_q;
        rgb_d       = rgb_q;
        sat_d       = sat_q;
        x_d         = x_q;
        y_d         = y_q;

        if (s1_advance) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_rgb_d = {conv_r[RGB_WIDTH-1:0], conv_g[RGB_WIDTH-1:0], conv_b[RGB_WIDTH-1:0]};
                s1_sat_d = conv_r[RGB_WIDTH] | conv_g[RGB_WIDTH] | conv_b[RGB_WIDTH];
            end
        end

        if (s2_advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rgb_d = s1_rgb_q;
                sat_d = s1_sat_q;
            end
        end

        // Coordinates belong to the pixel on the output, so they move only on its handshake.
        if (out_valid_q && out_ready) begin
            if (x_q == XLast) begin
                x_d = '0;
                y_d = (y_q == YLast) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_rgb_q    <= '0;
            s1_sat_q    <= 1'b0;
            out_valid_q <= 1'b0;
            rgb_q       <= '0;
            sat_q       <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_rgb_q    <= s1_rgb_d;
            s1_sat_q    <= s1_sat_d;
            out_valid_q <= out_valid_d;
            rgb_q       <= rgb_d;
            sat_q       <= sat_d;
            x_q         <= x_d;
            y_q         <= y_d;
        end
    end

    assign in_ready  = s1_advance;
    assign out_valid = out_valid_q;
    assign rgb_out   = rgb_q;
    assign sat_out   = sat_q;
    assign x_out     = x_q;
    assign y_out     = y_q;
    assign eol_out   = (x_q == XLast);
    assign eof_out   = (x_q == XLast) && (y_q == YLast);

endmodule
